// File: rtl/mux_4to1_assertion.sv
// Registered 4-to-1 multiplexer with one-hot selects. A single active select
// loads the matching input into the output register. No select or several
// selects hold the output and raise a one-cycle flag. Multi-select cycles are
// counted in a saturating error counter that only reset clears.
module mux_4to1_assertion #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_c,
    input  logic [WIDTH-1:0]     in_d,
    input  logic                 sel_a,
    input  logic                 sel_b,
    input  logic                 sel_c,
    input  logic                 sel_d,
    output logic [WIDTH-1:0]     out,
    output logic                 sel_none,
    output logic                 sel_multi,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    logic [3:0]           sel_vec;
    logic [WIDTH-1:0]     out_d;
    logic [WIDTH-1:0]     out_q;
    logic                 sel_none_d;
    logic                 sel_none_q;
    logic                 sel_multi_d;
    logic                 sel_multi_q;
    logic [CNT_WIDTH-1:0] err_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == {CNT_WIDTH{1'b1}}) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    assign sel_vec = {sel_d, sel_c, sel_b, sel_a};

    // Decode the select vector. Only exact one-hot patterns load data; the
    // case items compare 4-state, so any X/Z on a select falls to the illegal
    // (multi) branch in simulation.
    always_comb begin
        out_d       = out_q;
        sel_none_d  = 1'b0;
        sel_multi_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        case (sel_vec)
            4'b0001: out_d = in_a;
            4'b0010: out_d = in_b;
            4'b0100: out_d = in_c;
            4'b1000: out_d = in_d;
            4'b0000: sel_none_d = 1'b1;
            default: begin
                sel_multi_d = 1'b1;
                err_cnt_d   = sat_inc(err_cnt_q);
            end
        endcase
    end

    // Single capture register stage for data, flags and the error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            sel_none_q  <= 1'b0;
            sel_multi_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_q       <= out_d;
            sel_none_q  <= sel_none_d;
            sel_multi_q <= sel_multi_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out       = out_q;
    assign sel_none  = sel_none_q;
    assign sel_multi = sel_multi_q;
    assign err_cnt   = err_cnt_q;

`ifdef MUX_4TO1_ASSERT_ON
    // Protocol: at most one select active on every edge.
    a1_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(sel_vec))
        else $error("A1: illegal select pattern %b", sel_vec);

    // A single active select loads the matching input one cycle later.
    a2_sel_a: assert property (@(posedge clk) disable iff (!rst_n)
        (sel_vec == 4'b0001) |=> (out == $past(in_a)))
        else $error("A2: out does not follow in_a");
    a2_sel_b: assert property (@(posedge clk) disable iff (!rst_n)
        (sel_vec == 4'b0010) |=> (out == $past(in_b)))
        else $error("A2: out does not follow in_b");
    a2_sel_c: assert property (@(posedge clk) disable iff (!rst_n)
        (sel_vec == 4'b0100) |=> (out == $past(in_c)))
        else $error("A2: out does not follow in_c");
    a2_sel_d: assert property (@(posedge clk) disable iff (!rst_n)
        (sel_vec == 4'b1000) |=> (out == $past(in_d)))
        else $error("A2: out does not follow in_d");

    // No select or several selects hold the output.
    a3_hold: assert property (@(posedge clk) disable iff (!rst_n)
        !$onehot(sel_vec) |=> (out == $past(out)))
        else $error("A3: out changed without a single select");

    // The error counter is monotonic outside reset.
    a4_mono: assert property (@(posedge clk) disable iff (!rst_n)
        1'b1 |=> (err_cnt >= $past(err_cnt)))
        else $error("A4: err_cnt decreased");

    c_sel_a: cover property (@(posedge clk) disable iff (!rst_n) sel_vec == 4'b0001);
    c_sel_b: cover property (@(posedge clk) disable iff (!rst_n) sel_vec == 4'b0010);
    c_sel_c: cover property (@(posedge clk) disable iff (!rst_n) sel_vec == 4'b0100);
    c_sel_d: cover property (@(posedge clk) disable iff (!rst_n) sel_vec == 4'b1000);
    c_none:  cover property (@(posedge clk) disable iff (!rst_n) sel_vec == 4'b0000);
    c_multi: cover property (@(posedge clk) disable iff (!rst_n) !$onehot0(sel_vec));
`endif

endmodule

// File: tb/tb_mux_4to1_assertion.sv
// Directed bench for mux_4to1_assertion: a 16-bit-counter instance and a
// 2-bit-counter instance share one stimulus stream.
module tb_mux_4to1_assertion;

    logic        clk;
    logic        rst_n;
    logic        in_a, in_b, in_c, in_d;
    logic        sel_a, sel_b, sel_c, sel_d;
    logic        out_m, none_m, multi_m;
    logic [15:0] err_m;
    logic        out_s, none_s, multi_s;
    logic [1:0]  err_s;

    int checks = 0;
    int errors = 0;

    mux_4to1_assertion #(.WIDTH(1), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .sel_d(sel_d),
        .out(out_m), .sel_none(none_m), .sel_multi(multi_m), .err_cnt(err_m)
    );

    mux_4to1_assertion #(.WIDTH(1), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .sel_d(sel_d),
        .out(out_s), .sel_none(none_s), .sel_multi(multi_s), .err_cnt(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [3:0] s);
        {sel_d, sel_c, sel_b, sel_a} = s;
    endtask

    initial begin
        logic [3:0] rsel;
        logic       exp_out;
        int         k;

        rst_n = 1'b0;
        {in_d, in_c, in_b, in_a} = 4'b0000;
        set_sel(4'b0000);

        // Power-on reset state.
        #3;
        check("reset_out",   out_m,   0);
        check("reset_none",  none_m,  0);
        check("reset_multi", multi_m, 0);
        check("reset_err",   err_m,   0);
        check("reset_err_s", err_s,   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Legal one-hot selects: in_a=1, in_b=0, in_c=1, in_d=0.
        {in_d, in_c, in_b, in_a} = 4'b0101;
        set_sel(4'b0001); step();
        check("legal_a_out", out_m, 1);
        check("legal_a_none", none_m, 0);
        check("legal_a_multi", multi_m, 0);
        set_sel(4'b0010); step();
        check("legal_b_out", out_m, 0);
        set_sel(4'b0100); step();
        check("legal_c_out", out_m, 1);
        set_sel(4'b1000); step();
        check("legal_d_out", out_m, 0);
        check("legal_d_none", none_m, 0);
        check("legal_d_multi", multi_m, 0);
        check("legal_err", err_m, 0);

        // Load out=1, then three cycles with no select.
        set_sel(4'b0001); step();
        check("pre_none_out", out_m, 1);
        set_sel(4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("none_out", out_m, 1);
            check("none_flag", none_m, 1);
            check("none_multi", multi_m, 0);
        end

        // Two multi-select cycles (a and c) with both inputs 0: out must hold 1.
        in_a = 1'b0; in_c = 1'b0;
        set_sel(4'b0101);
        step();
        check("multi1_out", out_m, 1);
        check("multi1_flag", multi_m, 1);
        check("multi1_none", none_m, 0);
        check("multi1_err", err_m, 1);
        step();
        check("multi2_out", out_m, 1);
        check("multi2_flag", multi_m, 1);
        check("multi2_err", err_m, 2);
        check("multi2_err_s", err_s, 2);

        // Flags are pulses; counter holds after returning to a legal select.
        in_b = 1'b0;
        set_sel(4'b0010); step();
        check("post_multi_out", out_m, 0);
        check("post_multi_flag", multi_m, 0);
        check("post_multi_err", err_m, 2);

        // Saturation: five more multi cycles, 2-bit counter pins at 3.
        set_sel(4'b1111);
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_err_s", err_s, 3);
            check("sat_multi_s", multi_s, 1);
            check("sat_err_m", err_m, 3 + i);
        end
        set_sel(4'b0000); step();
        check("sat_hold_err_s", err_s, 3);
        check("sat_hold_none_s", none_s, 1);

        // Mid-run asynchronous reset with out=1.
        in_a = 1'b1;
        set_sel(4'b0001); step();
        check("pre_rst_out", out_m, 1);
        check("pre_rst_out_s", out_s, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out_m, 0);
        check("async_rst_err", err_m, 0);
        check("async_rst_err_s", err_s, 0);
        check("async_rst_out_s", out_s, 0);
        step();
        check("rst_hold_out", out_m, 0);
        check("rst_hold_err", err_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_out", out_m, 1);

        // Random data with legal one-hot selects, scoreboard on out.
        for (int i = 0; i < 1000; i++) begin
            {in_d, in_c, in_b, in_a} = 4'($urandom_range(0, 15));
            k = $urandom_range(0, 3);
            rsel = 4'b0001 << k;
            set_sel(rsel);
            case (k)
                0: exp_out = in_a;
                1: exp_out = in_b;
                2: exp_out = in_c;
                default: exp_out = in_d;
            endcase
            step();
            check("rand_out", out_m, exp_out);
        end
        check("rand_err", err_m, 0);
        check("rand_multi", multi_m, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
